wb_cmd_master: RTL and testbench
================================

Name: wb_cmd_master

Overview:
Wishbone classic single-transfer initiator that drives the user project's Wishbone slave port from an internal command/response stream. It is used for self-test, for an LA-driven bus exerciser, and in block-level benches that need bus traffic without the management SoC. Each accepted command becomes exactly one Wishbone cycle. Completion, error, or timeout is reported on a response channel with valid/ready flow control.

Parameters:
AW, 32, address width of cmd_adr_i and wbm_adr_o
DW, 32, data width; byte-select width is DW/8
TIMEOUT, 255, max cycles with stb high awaiting ack/err before abort (must be >= 1; used only with the optional feature)

Ports:
wb_clk_i  in  1  bus clock
wb_rst_ni  in  1  reset, asynchronous, active-low
cmd_valid_i  in  1  command offered
cmd_ready_o  out  1  command accepted when valid&ready at rising edge
cmd_we_i  in  1  1=write, 0=read
cmd_adr_i  in  AW  byte address
cmd_dat_i  in  DW  write data
cmd_sel_i  in  DW/8  byte selects
rsp_valid_o  out  1  response available
rsp_ready_i  in  1  response consumed when valid&ready at rising edge
rsp_dat_o  out  DW  read data (0 for writes and for errors)
rsp_err_o  out  1  transfer ended with err or timeout
rsp_timeout_o  out  1  transfer aborted by timeout
busy_o  out  1  high in any state other than IDLE
wbm_cyc_o  out  1  Wishbone cycle
wbm_stb_o  out  1  Wishbone strobe
wbm_we_o  out  1  Wishbone write enable
wbm_sel_o  out  DW/8  Wishbone byte selects
wbm_adr_o  out  AW  Wishbone address
wbm_dat_o  out  DW  Wishbone write data
wbm_dat_i  in  DW  Wishbone read data
wbm_ack_i  in  1  Wishbone acknowledge
wbm_err_i  in  1  Wishbone error

Behaviour:
- Reset is asynchronous on wb_rst_ni low. While in reset, all outputs are 0 and the state is IDLE. This holds even mid-transfer; cyc/stb drop immediately.
- State machine has three states: IDLE, BUS, RESP. All outputs are registered.
- IDLE:
  - cmd_ready_o=1.
  - On cmd_valid_i&cmd_ready_o, latch we/adr/dat/sel onto the wbm_* outputs, set cyc=stb=1, and go to BUS.
  - cyc and stb are therefore first visible the cycle after acceptance.
- BUS:
  - cmd_ready_o=0. cyc, stb, and all wbm_* outputs are held stable.
  - On an edge with wbm_err_i=1: drop cyc/stb; rsp_err_o=1, rsp_dat_o=0; go to RESP.
  - Else on an edge with wbm_ack_i=1: drop cyc/stb; rsp_err_o=0; rsp_dat_o=wbm_dat_i for reads, 0 for writes; go to RESP.
  - If ack and err are high together, err wins.
  - Latency: if ack is sampled at edge M, rsp_valid_o is high and cyc is low from M onward. Minimum command-to-response latency is 2 cycles (ack combinational in the first stb cycle).
- RESP:
  - rsp_valid_o=1. rsp_* are held stable until rsp_ready_i.
  - On valid&ready, clear rsp_valid_o and go to IDLE.
  - Minimum issue interval is 3 cycles; there is no command acceptance during RESP.
- ack or err outside BUS is ignored and has no effect.
- wbm_we/sel/adr/dat_o hold their last values after a cycle ends. cmd_* inputs are don't-care when not accepted.
- rsp_dat_o, rsp_err_o, and rsp_timeout_o hold their values after the handshake until the next response overwrites them.
- busy_o = (state != IDLE).

Optional Feature:
Macro WB_CMD_MASTER_TIMEOUT_EN.
- Defined:
  - An 8..32-bit counter (width clog2(TIMEOUT+1)) clears on entry to BUS and increments each BUS cycle without ack/err.
  - If the counter equals TIMEOUT at an edge with no ack/err, the transfer aborts: cyc/stb drop, rsp_err_o=1, rsp_timeout_o=1, rsp_dat_o=0, go to RESP.
  - An ack/err arriving on that same edge takes priority over the timeout.
- Not defined: there is no counter, BUS waits indefinitely, and rsp_timeout_o is tied 0.

Test Plan:
- Write: cmd we=1 adr=0x3000_0004 dat=0xDEADBEEF sel=0xF; slave acks after 2 wait cycles. Expected: wbm_* match, cyc/stb high for exactly 3 cycles, rsp_valid with err=0, dat=0.
- Read: cmd we=0 adr=0x3000_0008; slave returns 0x1234_5678 with ack in the first stb cycle. Expected: rsp_valid 2 cycles after acceptance, rsp_dat_o=0x12345678.
- Error: read where slave asserts err and ack in the same cycle. Expected: rsp_err_o=1, rsp_dat_o=0, cyc low the next cycle.
- Backpressure: rsp_ready_i held low for 5 cycles after rsp_valid. Expected: rsp held stable, cmd_ready_o=0 throughout, then IDLE one cycle after ready.
- Timeout (macro on, TIMEOUT=4): slave never responds. Expected: stb high for 5 cycles, then rsp_err_o=1, rsp_timeout_o=1; with macro off, cyc stays high for 100+ cycles.
- Reset mid-transfer: drive wb_rst_ni low while in BUS. Expected: cyc/stb/rsp_valid go 0 asynchronously (before the next edge); after release, cmd_ready_o=1 and a new read completes normally.

Source files
------------

// File: rtl/wb_cmd_master_if.sv
// rtl/wb_cmd_master_if.sv - command, response and Wishbone master signal bundle for wb_cmd_master
interface wb_cmd_master_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic            cmd_valid_i;
    logic            cmd_ready_o;
    logic            cmd_we_i;
    logic [AW-1:0]   cmd_adr_i;
    logic [DW-1:0]   cmd_dat_i;
    logic [DW/8-1:0] cmd_sel_i;

    logic            rsp_valid_o;
    logic            rsp_ready_i;
    logic [DW-1:0]   rsp_dat_o;
    logic            rsp_err_o;
    logic            rsp_timeout_o;
    logic            busy_o;

    logic            wbm_cyc_o;
    logic            wbm_stb_o;
    logic            wbm_we_o;
    logic [DW/8-1:0] wbm_sel_o;
    logic [AW-1:0]   wbm_adr_o;
    logic [DW-1:0]   wbm_dat_o;
    logic [DW-1:0]   wbm_dat_i;
    logic            wbm_ack_i;
    logic            wbm_err_i;

    modport master (
        input  cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i,
        output cmd_ready_o,
        input  rsp_ready_i,
        output rsp_valid_o, rsp_dat_o, rsp_err_o, rsp_timeout_o, busy_o,
        output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
        input  wbm_dat_i, wbm_ack_i, wbm_err_i
    );

    modport slave (
        output cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i,
        input  cmd_ready_o,
        output rsp_ready_i,
        input  rsp_valid_o, rsp_dat_o, rsp_err_o, rsp_timeout_o, busy_o,
        input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
        output wbm_dat_i, wbm_ack_i, wbm_err_i
    );
endinterface

// File: rtl/wb_cmd_master.sv
// rtl/wb_cmd_master.sv - single-transfer Wishbone classic initiator fed by a command/response stream
// Optional bus timeout abort enabled by defining WB_CMD_MASTER_TIMEOUT_EN.
module wb_cmd_master #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input logic              wb_clk_i,
    input logic              wb_rst_ni,
    wb_cmd_master_if.master  bus
);
    typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP} state_t;

    state_t          state_q, state_d;
    logic            ready_d, cyc_d, stb_d, we_d, rsp_valid_d, rsp_err_d;
    logic [DW/8-1:0] sel_d;
    logic [AW-1:0]   adr_d;
    logic [DW-1:0]   dat_d, rsp_dat_d;

`ifdef WB_CMD_MASTER_TIMEOUT_EN
    localparam int TW = ($clog2(TIMEOUT + 1) < 8) ? 8 : $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TO_LIMIT = TW'(TIMEOUT);
    logic [TW-1:0] cnt_q, cnt_d;
    logic          rsp_to_q, rsp_to_d;
    assign bus.rsp_timeout_o = rsp_to_q;
`else
    assign bus.rsp_timeout_o = 1'b0;
`endif

    assign bus.busy_o = (state_q != S_IDLE);

    always_comb begin
        state_d     = state_q;
        ready_d     = bus.cmd_ready_o;
        cyc_d       = bus.wbm_cyc_o;
        stb_d       = bus.wbm_stb_o;
        we_d        = bus.wbm_we_o;
        sel_d       = bus.wbm_sel_o;
        adr_d       = bus.wbm_adr_o;
        dat_d       = bus.wbm_dat_o;
        rsp_valid_d = bus.rsp_valid_o;
        rsp_err_d   = bus.rsp_err_o;
        rsp_dat_d   = bus.rsp_dat_o;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
        cnt_d       = cnt_q;
        rsp_to_d    = rsp_to_q;
`endif
        case (state_q)
            S_IDLE: begin
                ready_d = 1'b1;
                if (bus.cmd_valid_i && bus.cmd_ready_o) begin
                    we_d    = bus.cmd_we_i;
                    sel_d   = bus.cmd_sel_i;
                    adr_d   = bus.cmd_adr_i;
                    dat_d   = bus.cmd_dat_i;
                    cyc_d   = 1'b1;
                    stb_d   = 1'b1;
                    ready_d = 1'b0;
                    state_d = S_BUS;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            S_BUS: begin
                // err outranks ack; the timeout only fires on an otherwise quiet edge
                if (bus.wbm_err_i) begin
                    cyc_d = 1'b0; stb_d = 1'b0; rsp_valid_d = 1'b1; state_d = S_RESP;
                    rsp_err_d = 1'b1;
                    rsp_dat_d = '0;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
                    rsp_to_d  = 1'b0;
`endif
                end else if (bus.wbm_ack_i) begin
                    cyc_d = 1'b0; stb_d = 1'b0; rsp_valid_d = 1'b1; state_d = S_RESP;
                    rsp_err_d = 1'b0;
                    rsp_dat_d = bus.wbm_we_o ? '0 : bus.wbm_dat_i;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
                    rsp_to_d  = 1'b0;
`endif
                end
`ifdef WB_CMD_MASTER_TIMEOUT_EN
                else if (cnt_q == TO_LIMIT) begin
                    cyc_d = 1'b0; stb_d = 1'b0; rsp_valid_d = 1'b1; state_d = S_RESP;
                    rsp_err_d = 1'b1;
                    rsp_dat_d = '0;
                    rsp_to_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            S_RESP: begin
                if (bus.rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    ready_d     = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q         <= S_IDLE;
            bus.cmd_ready_o <= 1'b0;
            bus.wbm_cyc_o   <= 1'b0;
            bus.wbm_stb_o   <= 1'b0;
            bus.wbm_we_o    <= 1'b0;
            bus.wbm_sel_o   <= '0;
            bus.wbm_adr_o   <= '0;
            bus.wbm_dat_o   <= '0;
            bus.rsp_valid_o <= 1'b0;
            bus.rsp_err_o   <= 1'b0;
            bus.rsp_dat_o   <= '0;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
            cnt_q           <= '0;
            rsp_to_q        <= 1'b0;
`endif
        end else begin
            state_q         <= state_d;
            bus.cmd_ready_o <= ready_d;
            bus.wbm_cyc_o   <= cyc_d;
            bus.wbm_stb_o   <= stb_d;
            bus.wbm_we_o    <= we_d;
            bus.wbm_sel_o   <= sel_d;
            bus.wbm_adr_o   <= adr_d;
            bus.wbm_dat_o   <= dat_d;
            bus.rsp_valid_o <= rsp_valid_d;
            bus.rsp_err_o   <= rsp_err_d;
            bus.rsp_dat_o   <= rsp_dat_d;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
            cnt_q           <= cnt_d;
            rsp_to_q        <= rsp_to_d;
`endif
        end
    end
endmodule

// File: tb/tb_wb_cmd_master.sv
// tb/tb_wb_cmd_master.sv - directed self-checking bench for wb_cmd_master
module tb_wb_cmd_master;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    wb_cmd_master_if #(.AW(32), .DW(32)) bus ();

    wb_cmd_master #(.AW(32), .DW(32), .TIMEOUT(4)) dut (
        .wb_clk_i  (clk),
        .wb_rst_ni (rst_n),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n = 1'b1;
        bus.cmd_valid_i = 0; bus.cmd_we_i = 0; bus.cmd_adr_i = 0; bus.cmd_dat_i = 0; bus.cmd_sel_i = 0;
        bus.rsp_ready_i = 0; bus.wbm_dat_i = 0; bus.wbm_ack_i = 0; bus.wbm_err_i = 0;
        #1 rst_n = 1'b0;
        #20;
        chk("rst_cmd_ready", bus.cmd_ready_o, 0);
        chk("rst_cyc", bus.wbm_cyc_o, 0);
        chk("rst_rsp_valid", bus.rsp_valid_o, 0);
        chk("rst_busy", bus.busy_o, 0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("idle_cmd_ready", bus.cmd_ready_o, 1);

        // ack while idle must be ignored
        bus.wbm_ack_i = 1;
        tick();
        bus.wbm_ack_i = 0;
        chk("stray_ack_rsp_valid", bus.rsp_valid_o, 0);
        chk("stray_ack_cyc", bus.wbm_cyc_o, 0);

        // write, slave acks in the third stb cycle
        bus.cmd_valid_i = 1; bus.cmd_we_i = 1; bus.cmd_adr_i = 32'h3000_0004;
        bus.cmd_dat_i = 32'hDEAD_BEEF; bus.cmd_sel_i = 4'hF;
        tick();
        bus.cmd_valid_i = 0; bus.cmd_dat_i = 32'h0; bus.cmd_adr_i = 32'h0;
        chk("wr_stb_c1", bus.wbm_stb_o, 1);
        chk("wr_cyc", bus.wbm_cyc_o, 1);
        chk("wr_we", bus.wbm_we_o, 1);
        chk("wr_adr", bus.wbm_adr_o, 32'h3000_0004);
        chk("wr_dat", bus.wbm_dat_o, 32'hDEAD_BEEF);
        chk("wr_sel", bus.wbm_sel_o, 4'hF);
        chk("wr_cmd_ready", bus.cmd_ready_o, 0);
        chk("wr_busy", bus.busy_o, 1);
        tick();
        chk("wr_stb_c2", bus.wbm_stb_o, 1);
        tick();
        chk("wr_stb_c3", bus.wbm_stb_o, 1);
        chk("wr_adr_hold", bus.wbm_adr_o, 32'h3000_0004);
        bus.wbm_ack_i = 1; bus.wbm_dat_i = 32'h5555_AAAA;
        tick();
        bus.wbm_ack_i = 0;
        chk("wr_stb_end", bus.wbm_stb_o, 0);
        chk("wr_cyc_end", bus.wbm_cyc_o, 0);
        chk("wr_rsp_valid", bus.rsp_valid_o, 1);
        chk("wr_rsp_err", bus.rsp_err_o, 0);
        chk("wr_rsp_dat", bus.rsp_dat_o, 0);
        bus.rsp_ready_i = 1;
        tick();
        bus.rsp_ready_i = 0;
        chk("wr_done_valid", bus.rsp_valid_o, 0);
        chk("wr_done_ready", bus.cmd_ready_o, 1);
        chk("wr_done_busy", bus.busy_o, 0);

        // read with zero-wait ack, then response backpressure
        bus.cmd_valid_i = 1; bus.cmd_we_i = 0; bus.cmd_adr_i = 32'h3000_0008; bus.cmd_sel_i = 4'hF;
        tick();
        bus.cmd_valid_i = 0;
        chk("rd_cyc", bus.wbm_cyc_o, 1);
        chk("rd_we", bus.wbm_we_o, 0);
        chk("rd_adr", bus.wbm_adr_o, 32'h3000_0008);
        chk("rd_rsp_valid_early", bus.rsp_valid_o, 0);
        bus.wbm_ack_i = 1; bus.wbm_dat_i = 32'h1234_5678;
        tick();
        bus.wbm_ack_i = 0; bus.wbm_dat_i = 32'hFFFF_0000;
        chk("rd_rsp_valid", bus.rsp_valid_o, 1);
        chk("rd_rsp_dat", bus.rsp_dat_o, 32'h1234_5678);
        chk("rd_rsp_err", bus.rsp_err_o, 0);
        chk("rd_cyc_end", bus.wbm_cyc_o, 0);
        bus.cmd_valid_i = 1; bus.cmd_we_i = 1; bus.cmd_adr_i = 32'h3000_0100;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_rsp_valid", bus.rsp_valid_o, 1);
            chk("bp_rsp_dat", bus.rsp_dat_o, 32'h1234_5678);
            chk("bp_cmd_ready", bus.cmd_ready_o, 0);
            chk("bp_cyc", bus.wbm_cyc_o, 0);
        end
        bus.cmd_valid_i = 0;
        bus.rsp_ready_i = 1;
        tick();
        bus.rsp_ready_i = 0;
        chk("bp_done_valid", bus.rsp_valid_o, 0);
        chk("bp_done_ready", bus.cmd_ready_o, 1);
        chk("bp_dat_hold", bus.rsp_dat_o, 32'h1234_5678);

        // err and ack together: err wins
        bus.cmd_valid_i = 1; bus.cmd_we_i = 0; bus.cmd_adr_i = 32'h3000_000C;
        tick();
        bus.cmd_valid_i = 0;
        bus.wbm_ack_i = 1; bus.wbm_err_i = 1; bus.wbm_dat_i = 32'hAAAA_5555;
        tick();
        bus.wbm_ack_i = 0; bus.wbm_err_i = 0;
        chk("err_rsp_valid", bus.rsp_valid_o, 1);
        chk("err_rsp_err", bus.rsp_err_o, 1);
        chk("err_rsp_dat", bus.rsp_dat_o, 0);
        chk("err_rsp_timeout", bus.rsp_timeout_o, 0);
        chk("err_cyc", bus.wbm_cyc_o, 0);
        bus.rsp_ready_i = 1;
        tick();
        bus.rsp_ready_i = 0;

        // unresponsive slave
        bus.cmd_valid_i = 1; bus.cmd_we_i = 0; bus.cmd_adr_i = 32'h3000_0020;
        tick();
        bus.cmd_valid_i = 0;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
        for (int i = 0; i < 5; i++) begin
            chk("to_stb_high", bus.wbm_stb_o, 1);
            tick();
        end
        chk("to_stb_end", bus.wbm_stb_o, 0);
        chk("to_rsp_valid", bus.rsp_valid_o, 1);
        chk("to_rsp_err", bus.rsp_err_o, 1);
        chk("to_rsp_timeout", bus.rsp_timeout_o, 1);
        chk("to_rsp_dat", bus.rsp_dat_o, 0);
        bus.rsp_ready_i = 1;
        tick();
        bus.rsp_ready_i = 0;
        bus.cmd_valid_i = 1; bus.cmd_we_i = 0; bus.cmd_adr_i = 32'h3000_0024;
        tick();
        bus.cmd_valid_i = 0;
`else
        for (int i = 0; i < 120; i++) tick();
        chk("hang_cyc", bus.wbm_cyc_o, 1);
        chk("hang_stb", bus.wbm_stb_o, 1);
        chk("hang_rsp_valid", bus.rsp_valid_o, 0);
`endif

        // asynchronous reset while the cycle is open
        chk("mid_rst_cyc_before", bus.wbm_cyc_o, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_cyc", bus.wbm_cyc_o, 0);
        chk("mid_rst_stb", bus.wbm_stb_o, 0);
        chk("mid_rst_rsp_valid", bus.rsp_valid_o, 0);
        chk("mid_rst_busy", bus.busy_o, 0);
        #2 rst_n = 1'b1;
        tick();
        chk("post_rst_ready", bus.cmd_ready_o, 1);
        bus.cmd_valid_i = 1; bus.cmd_we_i = 0; bus.cmd_adr_i = 32'h3000_0010;
        tick();
        bus.cmd_valid_i = 0;
        chk("post_rst_adr", bus.wbm_adr_o, 32'h3000_0010);
        bus.wbm_ack_i = 1; bus.wbm_dat_i = 32'hCAFE_F00D;
        tick();
        bus.wbm_ack_i = 0;
        chk("post_rst_rsp_valid", bus.rsp_valid_o, 1);
        chk("post_rst_rsp_dat", bus.rsp_dat_o, 32'hCAFE_F00D);
        chk("post_rst_rsp_err", bus.rsp_err_o, 0);
        bus.rsp_ready_i = 1;
        tick();
        bus.rsp_ready_i = 0;
        chk("post_rst_idle", bus.cmd_ready_o, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
